dcf77_frame_decoder: RTL and testbench
======================================

# dcf77_frame_decoder

Upstream feeder for the `timeAndDate_Out`-format time-of-day clock. Decodes a demodulated DCF77 pulse train into the 44-bit packed BCD time/date word and a one-cycle load strobe that drive the clock's `timeAndDate_In` and `setTimeAndDate_in` ports. The load strobe fires at the start of second 00 of the decoded minute. Runs on the same 10 MHz clock and reset as the clock block.

## Interface
- `TICKS_PER_MS`, 10000: `clk` cycles per millisecond tick. Benches use small values.
- `clk`  in  1  system clock, 10 MHz.
- `nReset`  in  1  asynchronous, active-low reset.
- `dcf_in`  in  1  demodulated DCF77 signal, asynchronous. 1 = carrier reduced (pulse).
- `timeAndDate_Out`  out  44  decoded word:
  - [3:0]/[6:4] second (always 00).
  - [10:7]/[13:11] minute.
  - [17:14]/[19:18] hour.
  - [23:20]/[25:24] day.
  - [29:26]/[30] month.
  - [34:31]/[38:35] year.
  - [41:39] weekday, 1 = Mon … 7 = Sun.
  - [43:42] timezone `{Z1,Z2}`: 01 = CET, 10 = CEST.
- `setTimeAndDate_Out`  out  1  one-cycle strobe; `timeAndDate_Out` is valid in the same cycle.
- `dcfSynced`  out  1  last frame was valid and no error has occurred since.
- `frameError`  out  1  one-cycle strobe on any rejected frame or pulse.
- `bitCnt`  out  6  index of the next bit to be received, 0..59.

## Operation
- **Input sync:** `dcf_in` passes through a 2-FF synchronizer. A third flop provides rise/fall detection.
- **ms tick:** free-running prescaler counts 0..TICKS_PER_MS-1. `msCnt` (12 bit) counts ticks, clears on every `dcf_in` edge, and saturates at 4095.
- **FSM states:** HUNT (reset state), HIGH, LOW. An `armed` flag means frame alignment is known.
  - **HUNT:**
    - low time reaching 1500 ms sets `armed`.
    - low time reaching 2500 ms clears `armed` and `dcfSynced` (signal loss).
    - Rising edge with `armed`: go to HIGH and set `bitCnt` = 0. If a valid frame is pending, load it and strobe (see below).
    - Rising edge without `armed`: stay in HUNT.
  - **HIGH:**
    - Falling edge with high time 40..139 ms: bit = 0.
    - Falling edge with high time 140..259 ms: bit = 1.
    - Either bit value is written to `frame[bitCnt]`, then `bitCnt`++, then go to LOW.
    - Falling edge with high time <40 ms, or high time reaching 260 ms: error.
  - **LOW:**
    - Rising edge with low time <700 ms: error.
    - Rising edge with low time 700..1499 ms: go to HIGH, unless `bitCnt` == 59, which is an error.
    - Low time reaching 1500 ms: minute marker. Evaluate the frame, set `armed`, go to HUNT.
- **Error:**
  - Pulse `frameError`, clear `dcfSynced`, clear `armed`, drop any pending frame, go to HUNT.
  - A marker-time failure is the exception: it still sets `armed`.
- **Frame checks at marker:**
  - `bitCnt` == 59.
  - bit 0 = 0 and bit 20 = 1.
  - Even parity over bits 21..28, over 29..35, and over 36..58.
  - `{bit17,bit18}` ∈ {01,10}.
  - Pass: build the output word from bits 21..57 (seconds = 0) into a pending register and set `pending`.
  - Fail: pulse `frameError` and clear `dcfSynced`.
- **Load:**
  - Triggered by the next rising edge while `pending` is set.
  - Register `timeAndDate_Out` from pending, pulse `setTimeAndDate_Out`, set `dcfSynced`, clear `pending`.
  - `timeAndDate_Out` holds its value between loads.
- **Unused bits:** bits 1..16 and 19 (weather, call, A1, A2) are ignored. A leap-second minute (60 bits) is rejected as an error.

## Timing
- **Reset:**
  - Outputs: `timeAndDate_Out` = 0, `setTimeAndDate_Out` = 0, `dcfSynced` = 0, `frameError` = 0, `bitCnt` = 0.
  - Internal: FSM = HUNT, `armed` = 0, `pending` = 0, prescaler = 0, `msCnt` = 0.
  - Reset mid-frame discards all partial data.
- **Strobe latency:** `setTimeAndDate_Out` is high exactly on the 3rd rising `clk` edge after the first edge that samples `dcf_in` = 1.
- **Strobe widths:** `setTimeAndDate_Out` and `frameError` are exactly 1 cycle wide and never asserted in the same cycle.
- **Threshold resolution:** ms thresholds are evaluated on tick boundaries, with ±1 ms quantization.
- **Simultaneous events:** if a tick and an edge occur in the same cycle, the edge wins. The classification uses `msCnt` before the increment.

## Configuration
- `DCF77_PLAUSIBILITY_EN` defined:
  - Adds these checks at the marker: every BCD ones digit ≤9, minute ≤59, hour ≤23, day 01..31, month 01..12, weekday 1..7.
  - Any failure produces `frameError`.
- Undefined: only bit-count, marker-bit, parity and timezone checks apply.

## Test plan
- **Valid frame:** reset, then 2 s low, then a frame for 23:59 Tue 30.07.19 CEST with correct parities, then the marker, then a rising edge.
  - One `setTimeAndDate_Out` pulse.
  - `timeAndDate_Out` fields: min 5/9, hour 2/3, day 3/0, month 0/7, year 1/9, weekday 010, tz 10, sec 00.
  - `dcfSynced` = 1.
- **Bad parity:** same frame with bit 35 (P2) flipped.
  - `frameError` pulses at the marker.
  - No strobe; `timeAndDate_Out` unchanged; `dcfSynced` = 0.
  - The next correct frame is accepted without re-hunting.
- **Short frame:** only 58 bits before the marker → `frameError`, `bitCnt` was 58, no strobe.
- **Bad pulse width:** a 300 ms pulse mid-frame → `frameError` at 260 ms, FSM in HUNT. Bits are ignored until the next 1500 ms gap.
- **Loss and reset:**
  - `dcf_in` held low 2600 ms after sync → `dcfSynced` falls at 2500 ms.
  - `nReset` asserted mid-frame → all outputs 0 immediately.
- **Plausibility:** month = 13 with correct parity → rejected with `DCF77_PLAUSIBILITY_EN` defined, loaded with it undefined.

Source files
------------

// File: rtl/dcf77_frame_decoder.sv
// DCF77 pulse-train decoder feeding the time-of-day clock's load port.
// Define DCF77_PLAUSIBILITY_EN to add BCD range checks at the minute marker.
`timescale 1ns/1ps
module dcf77_frame_decoder #(
    parameter int TICKS_PER_MS = 10000,
    parameter int TIME_DIV     = 1
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        dcf_in,
    output logic [43:0] timeAndDate_Out,
    output logic        setTimeAndDate_Out,
    output logic        dcfSynced,
    output logic        frameError,
    output logic [5:0]  bitCnt
);
    // TIME_DIV compresses every ms threshold; 1 gives the real DCF77 timing
    localparam logic [11:0] T_MIN   = 12'(40 / TIME_DIV);
    localparam logic [11:0] T_ONE   = 12'(140 / TIME_DIV);
    localparam logic [11:0] T_MAXH  = 12'(260 / TIME_DIV);
    localparam logic [11:0] T_MINL  = 12'(700 / TIME_DIV);
    localparam logic [11:0] T_MARK  = 12'(1500 / TIME_DIV);
    localparam logic [11:0] T_LOSS  = 12'(2500 / TIME_DIV);
    localparam int          PW      = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_MS - 1);

    typedef enum logic [1:0] {HUNT, HIGH, LOW} state_t;

    logic          s1_q, s2_q, s3_q;
    logic          rise, fall, edg, tick;
    logic [PW-1:0] pre_q;
    logic [11:0]   ms_q, ms_d;
    state_t        state_q, state_d;
    logic          armed_q, armed_d;
    logic          pend_q, pend_d;
    logic [43:0]   pword_q, pword_d;
    logic [58:0]   frame_q, frame_d;
    logic [43:0]   out_q, out_d;
    logic          set_q, set_d;
    logic          sync_q, sync_d;
    logic          err_q, err_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [43:0]   word;
    logic          frame_ok, plaus_ok, do_err;
    logic          unused_bits;

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;
    assign edg  = rise | fall;
    assign tick = (pre_q == PRE_MAX);

    assign word = {frame_q[17], frame_q[18], frame_q[44:42],
                   frame_q[57:54], frame_q[53:50],
                   frame_q[49], frame_q[48:45],
                   frame_q[41:40], frame_q[39:36],
                   frame_q[34:33], frame_q[32:29],
                   frame_q[27:25], frame_q[24:21], 7'd0};

    // weather, call and announcement bits carry nothing for the clock
    assign unused_bits = ^{frame_q[16:1], frame_q[19]};

`ifdef DCF77_PLAUSIBILITY_EN
    assign plaus_ok = (word[10:7] <= 4'd9) && (word[13:11] <= 3'd5)
        && (word[17:14] <= 4'd9)
        && ((word[19:18] < 2'd2)
            || (word[19:18] == 2'd2 && word[17:14] <= 4'd3))
        && (word[23:20] <= 4'd9) && (word[25:20] != 6'd0)
        && ((word[25:24] < 2'd3) || (word[23:20] <= 4'd1))
        && (word[29:26] <= 4'd9) && (word[30:26] != 5'd0)
        && (!word[30] || word[29:26] <= 4'd2)
        && (word[34:31] <= 4'd9) && (word[41:39] != 3'd0);
`else
    assign plaus_ok = 1'b1;
`endif

    assign frame_ok = (cnt_q == 6'd59) && !frame_q[0] && frame_q[20]
        && !(^frame_q[28:21]) && !(^frame_q[35:29])
        && !(^frame_q[58:36]) && (frame_q[17] ^ frame_q[18])
        && plaus_ok;

    always_comb begin
        ms_d = ms_q;
        if (edg) begin
            ms_d = '0;
        end else if (tick && ms_q != 12'hFFF) begin
            ms_d = ms_q + 12'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        pend_d  = pend_q;
        pword_d = pword_q;
        frame_d = frame_q;
        out_d   = out_q;
        set_d   = 1'b0;
        sync_d  = sync_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        do_err  = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (rise) begin
                    if (armed_q) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                        if (pend_q) begin
                            out_d  = pword_q;
                            set_d  = 1'b1;
                            sync_d = 1'b1;
                            pend_d = 1'b0;
                        end
                    end
                end else if (!s2_q && ms_q >= T_LOSS) begin
                    armed_d = 1'b0;
                    sync_d  = 1'b0;
                    pend_d  = 1'b0;
                end else if (!s2_q && ms_q >= T_MARK) begin
                    armed_d = 1'b1;
                end
            end
            HIGH: begin
                if (fall) begin
                    if (ms_q < T_MIN || ms_q >= T_MAXH) begin
                        do_err = 1'b1;
                    end else begin
                        frame_d[cnt_q] = (ms_q >= T_ONE);
                        cnt_d   = cnt_q + 6'd1;
                        state_d = LOW;
                    end
                end else if (ms_q >= T_MAXH) begin
                    do_err = 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    if (ms_q < T_MINL || ms_q >= T_MARK
                        || cnt_q == 6'd59) begin
                        do_err = 1'b1;
                    end else begin
                        state_d = HIGH;
                    end
                end else if (ms_q >= T_MARK) begin
                    // a failed marker still leaves frame alignment known
                    state_d = HUNT;
                    armed_d = 1'b1;
                    if (frame_ok) begin
                        pword_d = word;
                        pend_d  = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        sync_d = 1'b0;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
        if (do_err) begin
            err_d   = 1'b1;
            sync_d  = 1'b0;
            armed_d = 1'b0;
            pend_d  = 1'b0;
            state_d = HUNT;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            pre_q   <= '0;
            ms_q    <= '0;
            state_q <= HUNT;
            armed_q <= 1'b0;
            pend_q  <= 1'b0;
            pword_q <= '0;
            frame_q <= '0;
            out_q   <= '0;
            set_q   <= 1'b0;
            sync_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= dcf_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pre_q   <= tick ? '0 : pre_q + 1'b1;
            ms_q    <= ms_d;
            state_q <= state_d;
            armed_q <= armed_d;
            pend_q  <= pend_d;
            pword_q <= pword_d;
            frame_q <= frame_d;
            out_q   <= out_d;
            set_q   <= set_d;
            sync_q  <= sync_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign timeAndDate_Out    = out_q;
    assign setTimeAndDate_Out = set_q;
    assign dcfSynced          = sync_q;
    assign frameError         = err_q;
    assign bitCnt             = cnt_q;
endmodule

// File: tb/tb_dcf77_frame_decoder.sv
// Directed bench for dcf77_frame_decoder: frame table plus corner sequences.
// One bench cycle = 10 ms of DCF77 time (TICKS_PER_MS=2, TIME_DIV=20).
`timescale 1ns/1ps
module tb_dcf77_frame_decoder;
    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        dcf_in = 1'b0;
    logic [43:0] timeAndDate_Out;
    logic        setTimeAndDate_Out;
    logic        dcfSynced;
    logic        frameError;
    logic [5:0]  bitCnt;

    dcf77_frame_decoder #(
        .TICKS_PER_MS(2),
        .TIME_DIV(20)
    ) dut (
        .clk(clk),
        .nReset(nReset),
        .dcf_in(dcf_in),
        .timeAndDate_Out(timeAndDate_Out),
        .setTimeAndDate_Out(setTimeAndDate_Out),
        .dcfSynced(dcfSynced),
        .frameError(frameError),
        .bitCnt(bitCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  mi, hr, dy, mo, yr;
        logic [2:0]  wd;
        logic        cest;
        int          flip;
        int          nbits;
        logic        err;
        logic        load;
        logic        loss;
        logic [43:0] word;
    } vec_t;

    localparam int NV = 7;
    vec_t vec [NV];

    int nvec = 0;
    int nfail = 0;
    int nerr = 0;
    int nset = 0;
    int nboth = 0;
    int errBit = 0;
    logic [43:0] curWord = '0;

`ifdef DCF77_PLAUSIBILITY_EN
    localparam logic PL = 1'b1;
`else
    localparam logic PL = 1'b0;
`endif

    always @(negedge clk) begin
        if (frameError) begin
            nerr++;
            errBit = int'(bitCnt);
        end
        if (setTimeAndDate_Out) nset++;
        if (frameError && setTimeAndDate_Out) nboth++;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int lowc);
        dcf_in = 1'b1;
        wait_cyc(b ? 20 : 10);
        dcf_in = 1'b0;
        wait_cyc(lowc);
    endtask

    function automatic logic [59:0] mkframe(input vec_t v);
        logic [59:0] f = '0;
        f[17]    = v.cest;
        f[18]    = ~v.cest;
        f[20]    = 1'b1;
        f[24:21] = v.mi[3:0];
        f[27:25] = v.mi[6:4];
        f[28]    = ^f[27:21];
        f[32:29] = v.hr[3:0];
        f[34:33] = v.hr[5:4];
        f[35]    = ^f[34:29];
        f[39:36] = v.dy[3:0];
        f[41:40] = v.dy[5:4];
        f[44:42] = v.wd;
        f[48:45] = v.mo[3:0];
        f[49]    = v.mo[4];
        f[53:50] = v.yr[3:0];
        f[57:54] = v.yr[7:4];
        f[58]    = ^f[57:36];
        if (v.flip >= 0) f[v.flip] = ~f[v.flip];
        return f;
    endfunction

    // Rising edge that starts a second-00 pulse (a 0 bit, 100 ms high)
    task automatic rise_check(input logic load, input logic [43:0] w);
        int seen = 0;
        int at = 0;
        logic [43:0] wAt = '0;
        dcf_in = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            wait_cyc(1);
            if (setTimeAndDate_Out) begin
                seen++;
                if (at == 0) at = c;
                wAt = timeAndDate_Out;
            end
        end
        if (load) begin
            chk("strobe_latency", 64'(at), 64'd3);
            chk("strobe_width", 64'(seen), 64'd1);
            chk("load_word", 64'(wAt), 64'(w));
            curWord = w;
        end else begin
            chk("no_strobe", 64'(seen), 64'd0);
        end
        wait_cyc(4);
        chk("held_word", 64'(timeAndDate_Out), 64'(curWord));
        chk("synced", 64'(dcfSynced), 64'(load));
        dcf_in = 1'b0;
        wait_cyc(90);
    endtask

    task automatic send_frame(input vec_t v);
        logic [59:0] f;
        int e0;
        f = mkframe(v);
        e0 = nerr;
        for (int j = 1; j < v.nbits; j++) begin
            if (j == v.nbits - 1) send_bit(f[j], 180);
            else send_bit(f[j], f[j] ? 80 : 90);
        end
        chk("marker_err", 64'(nerr - e0), 64'(v.err));
        chk("marker_bitcnt", 64'(bitCnt), 64'(v.nbits));
        if (v.err) chk("err_bitcnt", 64'(errBit), 64'(v.nbits));
        if (v.loss) begin
            wait_cyc(60);
            chk("synced_before_loss", 64'(dcfSynced), 64'd1);
            wait_cyc(25);
            chk("synced_after_loss", 64'(dcfSynced), 64'd0);
        end
    endtask

    initial begin
        int e0;
        int nload = 0;
        vec[0] = '{8'h59, 8'h23, 8'h30, 8'h07, 8'h19, 3'd2, 1'b1, -1, 59,
                   1'b0, 1'b1, 1'b0,
                   {2'b10, 3'd2, 4'd1, 4'd9, 1'b0, 4'd7, 2'd3, 4'd0,
                    2'd2, 4'd3, 3'd5, 4'd9, 7'd0}};
        vec[1] = vec[0];
        vec[1].flip = 35;
        vec[1].err  = 1'b1;
        vec[1].load = 1'b0;
        vec[2] = '{8'h00, 8'h00, 8'h31, 8'h07, 8'h19, 3'd3, 1'b1, -1, 59,
                   1'b0, 1'b1, 1'b0,
                   {2'b10, 3'd3, 4'd1, 4'd9, 1'b0, 4'd7, 2'd3, 4'd1,
                    2'd0, 4'd0, 3'd0, 4'd0, 7'd0}};
        vec[3] = vec[2];
        vec[3].nbits = 58;
        vec[3].err   = 1'b1;
        vec[3].load  = 1'b0;
        vec[4] = '{8'h34, 8'h12, 8'h15, 8'h13, 8'h24, 3'd5, 1'b0, -1, 59,
                   PL, ~PL, 1'b0,
                   {2'b01, 3'd5, 4'd2, 4'd4, 1'b1, 4'd3, 2'd1, 4'd5,
                    2'd1, 4'd2, 3'd3, 4'd4, 7'd0}};
        vec[5] = '{8'h35, 8'h12, 8'h16, 8'h12, 8'h24, 3'd6, 1'b0, -1, 59,
                   1'b0, 1'b1, 1'b0,
                   {2'b01, 3'd6, 4'd2, 4'd4, 1'b1, 4'd2, 2'd1, 4'd6,
                    2'd1, 4'd2, 3'd3, 4'd5, 7'd0}};
        // valid frame, but the signal vanishes before its load edge
        vec[6] = '{8'h36, 8'h12, 8'h16, 8'h12, 8'h24, 3'd7, 1'b0, -1, 59,
                   1'b0, 1'b0, 1'b1,
                   {2'b01, 3'd7, 4'd2, 4'd4, 1'b1, 4'd2, 2'd1, 4'd6,
                    2'd1, 4'd2, 3'd3, 4'd6, 7'd0}};

        wait_cyc(3);
        chk("rst_word", 64'(timeAndDate_Out), 64'd0);
        chk("rst_bitcnt", 64'(bitCnt), 64'd0);
        chk("rst_synced", 64'(dcfSynced), 64'd0);
        chk("rst_strobe", 64'(setTimeAndDate_Out), 64'd0);
        chk("rst_err", 64'(frameError), 64'd0);
        nReset = 1'b1;
        wait_cyc(200);

        for (int i = 0; i < NV; i++) begin
            if (i == 0) rise_check(1'b0, '0);
            else rise_check(vec[i-1].load, vec[i-1].word);
            send_frame(vec[i]);
            if (vec[i].load) nload++;
        end
        rise_check(vec[NV-1].load, vec[NV-1].word);

        // over-long pulse mid-frame, then hunting for the next marker
        wait_cyc(100);
        for (int k = 0; k < 3; k++) send_bit(1'b0, 90);
        chk("bitcnt_3bits", 64'(bitCnt), 64'd3);
        e0 = nerr;
        dcf_in = 1'b1;
        wait_cyc(30);
        dcf_in = 1'b0;
        wait_cyc(70);
        chk("long_pulse_err", 64'(nerr - e0), 64'd1);
        chk("long_pulse_synced", 64'(dcfSynced), 64'd0);
        send_bit(1'b1, 80);
        send_bit(1'b0, 90);
        chk("hunt_ignores_bits", 64'(bitCnt), 64'd3);
        wait_cyc(100);
        send_bit(1'b1, 50);
        chk("rearm_bitcnt", 64'(bitCnt), 64'd1);
        chk("hunt_no_err", 64'(nerr - e0), 64'd1);

        // reset mid-pulse
        dcf_in = 1'b1;
        wait_cyc(5);
        nReset = 1'b0;
        #1;
        chk("midrst_word", 64'(timeAndDate_Out), 64'd0);
        chk("midrst_bitcnt", 64'(bitCnt), 64'd0);
        chk("midrst_synced", 64'(dcfSynced), 64'd0);
        chk("midrst_strobe", 64'(setTimeAndDate_Out), 64'd0);
        chk("midrst_err", 64'(frameError), 64'd0);
        dcf_in = 1'b0;
        wait_cyc(5);
        nReset = 1'b1;
        wait_cyc(5);

        chk("strobe_total", 64'(nset), 64'(nload));
        chk("strobe_err_overlap", 64'(nboth), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
